// File: rtl/aes_256_sched_if.sv
// Requester, core and result signals of the aes_256 two-requester scheduler.
// slave is the scheduler side; master is the environment that drives it.
interface aes_256_sched_if;
    logic         req0_valid;
    logic         req0_ready;
    logic [127:0] req0_state;
    logic [255:0] req0_key;
    logic         req1_valid;
    logic         req1_ready;
    logic [127:0] req1_state;
    logic [255:0] req1_key;
    logic [127:0] core_state;
    logic [255:0] core_key;
    logic [127:0] core_out;
    logic         res_valid;
    logic         res_ready;
    logic         res_id;
    logic [127:0] res_data;

    modport slave (
        input  req0_valid, req0_state, req0_key,
        input  req1_valid, req1_state, req1_key,
        input  core_out, res_ready,
        output req0_ready, req1_ready,
        output core_state, core_key,
        output res_valid, res_id, res_data
    );

    modport master (
        output req0_valid, req0_state, req0_key,
        output req1_valid, req1_state, req1_key,
        output core_out, res_ready,
        input  req0_ready, req1_ready,
        input  core_state, core_key,
        input  res_valid, res_id, res_data
    );
endinterface

// File: rtl/aes_256_sched.sv
// Two-requester scheduler feeding a non-stallable pipelined aes_256 core, with a credit-guarded
// result FIFO. Define AES_SCHED_FIXED_PRIO_EN for fixed priority (requester 0 always wins ties).
module aes_256_sched #(
    parameter int unsigned LATENCY    = 29,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input logic            clk,
    input logic            rst_n,
    aes_256_sched_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] CreditsMax = CW'(FIFO_DEPTH);

    logic          grant0;
    logic          grant1;
    logic          accept;
    logic          push;
    logic          pop;
    logic          res_valid;
    logic [128:0]  head;

    logic [CW-1:0] credits_q, credits_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [127:0]  core_state_q;
    logic [255:0]  core_key_q;
    // Stage 0 is aligned with the core input register; stage LATENCY with core_out.
    logic [LATENCY:0] tag_valid_q;
    logic [LATENCY:0] tag_id_q;
    logic [128:0]  mem_q [FIFO_DEPTH];

    // Arbitration
`ifdef AES_SCHED_FIXED_PRIO_EN
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (credits_q != '0) begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid & ~bus.req0_valid;
        end
    end
`else
    logic last_q, last_d;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (credits_q != '0) begin
            grant0 = bus.req0_valid & (~bus.req1_valid | last_q);
            grant1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
        end
    end

    always_comb begin
        last_d = last_q;
        if (accept) begin
            last_d = grant1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign accept         = grant0 | grant1;
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Core input registers hold their value when idle to avoid needless toggling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_state_q <= '0;
            core_key_q   <= '0;
        end else if (accept) begin
            core_state_q <= grant1 ? bus.req1_state : bus.req0_state;
            core_key_q   <= grant1 ? bus.req1_key : bus.req0_key;
        end
    end

    assign bus.core_state = core_state_q;
    assign bus.core_key   = core_key_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_q <= '0;
            tag_id_q    <= '0;
        end else begin
            tag_valid_q <= {tag_valid_q[LATENCY-1:0], accept};
            tag_id_q    <= {tag_id_q[LATENCY-1:0], grant1};
        end
    end

    // Result FIFO
    assign push      = tag_valid_q[LATENCY];
    assign res_valid = (count_q != '0);
    assign pop       = res_valid & bus.res_ready;
    assign head      = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {tag_id_q[LATENCY], bus.core_out};
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    assign bus.res_valid = res_valid;
    assign bus.res_id    = res_valid ? head[128] : 1'b0;
    assign bus.res_data  = res_valid ? head[127:0] : '0;

    // Credits cover blocks in flight plus blocks buffered, so a push always finds room.
    always_comb begin
        credits_d = credits_q;
        unique case ({accept, pop})
            2'b10:   credits_d = credits_q - CW'(1);
            2'b01:   credits_d = credits_q + CW'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_q <= CreditsMax;
        end else begin
            credits_q <= credits_d;
        end
    end
endmodule

// File: tb/tb_aes_256_sched.sv
// Randomized self-checking bench for aes_256_sched: behavioural AES-256 core model plus a
// transaction-level scoreboard of grants, credits, result order and result latency.
module tb_aes_256_sched;
    localparam int unsigned LATENCY    = 29;
    localparam int unsigned FIFO_DEPTH = 32;

    typedef struct {
        logic         id;
        logic [127:0] data;
        int           avail;
    } exp_t;

    logic clk;
    logic rst_n;

    aes_256_sched_if bus ();

    aes_256_sched #(
        .LATENCY   (LATENCY),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   n_acc    = 0;
    int   m_out    = 0;
    logic m_last   = 1'b1;
    exp_t exp_q[$];
    logic grant_log[$];
    logic [7:0]   sbox_t [256];
    logic [127:0] pipe [LATENCY];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // AES-256 reference
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int s);
        return (x << s) | (x >> (8 - s));
    endfunction

    initial begin
        logic [7:0] p, q;
        p = 8'h01;
        q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            sbox_t[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
        end
        sbox_t[0] = 8'h63;
    end

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    function automatic logic [127:0] aes256(input logic [127:0] pt, input logic [255:0] key);
        logic [31:0]  w [60];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   n [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i - 1];
            if (i % 8 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i - 8] ^ t;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ w[i / 4][31 - 8 * (i % 4) -: 8];
        for (int r = 1; r <= 14; r++) begin
            for (int i = 0; i < 16; i++) n[i] = sbox_t[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
            if (r != 14) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = n[4 * c];
                    a1 = n[4 * c + 1];
                    a2 = n[4 * c + 2];
                    a3 = n[4 * c + 3];
                    n[4 * c]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    n[4 * c + 1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    n[4 * c + 2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    n[4 * c + 3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = n[i] ^ w[4 * r + i / 4][31 - 8 * (i % 4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    // Pipelined core model: core_out changes LATENCY edges after its inputs.
    always @(posedge clk) begin
        pipe[0] <= aes256(bus.core_state, bus.core_key);
        for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i - 1];
    end
    assign bus.core_out = pipe[LATENCY - 1];

    // Scoreboard, evaluated mid-cycle on settled combinational outputs.
    always @(negedge clk) begin
        logic e0, e1, erv;
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            m_out  = 0;
            m_last = 1'b1;
        end else begin
            e0 = 1'b0;
            e1 = 1'b0;
            if (m_out < FIFO_DEPTH) begin
`ifdef AES_SCHED_FIXED_PRIO_EN
                e0 = bus.req0_valid;
                e1 = bus.req1_valid && !bus.req0_valid;
`else
                e0 = bus.req0_valid && (!bus.req1_valid || m_last);
                e1 = bus.req1_valid && (!bus.req0_valid || !m_last);
`endif
            end
            check("req0_ready", 128'(bus.req0_ready), 128'(e0));
            check("req1_ready", 128'(bus.req1_ready), 128'(e1));
            check("credits", 128'(dut.credits_q), 128'(FIFO_DEPTH - m_out));
            check("fifo_bound", 128'(dut.count_q <= FIFO_DEPTH), 128'(1));
            check("conserve", 128'(int'(dut.credits_q) + int'(dut.count_q)
                  + $countones(dut.tag_valid_q)), 128'(FIFO_DEPTH));
            erv = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
            check("res_valid", 128'(bus.res_valid), 128'(erv));
            if (bus.res_valid && exp_q.size() > 0) begin
                check("res_id", 128'(bus.res_id), 128'(exp_q[0].id));
                check("res_data", bus.res_data, exp_q[0].data);
                if (bus.res_ready) begin
                    void'(exp_q.pop_front());
                    m_out--;
                end
            end
            if (bus.req0_valid && bus.req0_ready) begin
                e = '{1'b0, aes256(bus.req0_state, bus.req0_key), cyc + LATENCY + 2};
                exp_q.push_back(e);
                m_out++;
                m_last = 1'b0;
                n_acc++;
                grant_log.push_back(1'b0);
            end
            if (bus.req1_valid && bus.req1_ready) begin
                e = '{1'b1, aes256(bus.req1_state, bus.req1_key), cyc + LATENCY + 2};
                exp_q.push_back(e);
                m_out++;
                m_last = 1'b1;
                n_acc++;
                grant_log.push_back(1'b1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        bus.req0_state = {$urandom, $urandom, $urandom, $urandom};
        bus.req0_key   = {$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom};
        bus.req1_state = {$urandom, $urandom, $urandom, $urandom};
        bus.req1_key   = {$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic apply_reset();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [127:0] fips_pt, fips_ct;
        logic [255:0] fips_key;
        int base, hi, seen;
        fips_pt  = 128'h00112233445566778899aabbccddeeff;
        fips_key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        fips_ct  = 128'h8ea2b7ca516745bfeafc49904b496089;
        rst_n = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.res_ready  = 1'b1;
        rand_data();
        #2;

        // Reset values
        rst_n = 1'b0;
        tick(2);
        check("rst_core_state", bus.core_state, 128'h0);
        check("rst_core_key", 128'(bus.core_key != '0), 128'h0);
        check("rst_res_valid", 128'(bus.res_valid), 128'h0);
        check("rst_res_id", 128'(bus.res_id), 128'h0);
        check("rst_res_data", bus.res_data, 128'h0);
        check("rst_credits", 128'(dut.credits_q), 128'(FIFO_DEPTH));
        bus.req0_valid = 1'b1;
        #1;
        check("rst_ready0", 128'(bus.req0_ready), 128'h1);
        bus.req0_valid = 1'b0;
        tick(1);
        rst_n = 1'b1;

        // FIPS-197 C.3 single block
        bus.req0_state = fips_pt;
        bus.req0_key   = fips_key;
        bus.req0_valid = 1'b1;
        tick(1);
        bus.req0_valid = 1'b0;
        check("fips_core_state", bus.core_state, fips_pt);
        tick(LATENCY);
        check("fips_early", 128'(bus.res_valid), 128'h0);
        tick(1);
        check("fips_valid", 128'(bus.res_valid), 128'h1);
        check("fips_id", 128'(bus.res_id), 128'h0);
        check("fips_data", bus.res_data, fips_ct);
        tick(3);

        // Contention from reset
        apply_reset();
        grant_log.delete();
        for (int i = 0; i < 8; i++) begin
            rand_data();
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
            tick(1);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("cont_grants", 128'(grant_log.size()), 128'h8);
        for (int i = 0; i < grant_log.size(); i++) begin
`ifdef AES_SCHED_FIXED_PRIO_EN
            check("cont_order", 128'(grant_log[i]), 128'h0);
`else
            check("cont_order", 128'(grant_log[i]), 128'(i % 2));
`endif
        end
        tick(LATENCY + 12);
        check("cont_drained", 128'(exp_q.size()), 128'h0);

        // Back-pressure
        apply_reset();
        bus.res_ready  = 1'b0;
        base = n_acc;
        for (int i = 0; i < 45; i++) begin
            rand_data();
            bus.req0_valid = 1'b1;
            tick(1);
        end
        check("bp_accepts", 128'(n_acc - base), 128'(FIFO_DEPTH));
        check("bp_ready_low", 128'(bus.req0_ready), 128'h0);
        bus.res_ready = 1'b1;
        tick(1);
        bus.res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rand_data();
            tick(1);
        end
        check("bp_one_more", 128'(n_acc - base), 128'(FIFO_DEPTH + 1));
        bus.req0_valid = 1'b0;
        bus.res_ready  = 1'b1;
        tick(LATENCY + FIFO_DEPTH + 20);
        check("bp_drained", 128'(exp_q.size()), 128'h0);

        // Full rate with simultaneous push/pop
        apply_reset();
        base = n_acc;
        for (int i = 0; i < 100; i++) begin
            rand_data();
            bus.req0_valid = 1'b1;
            tick(1);
        end
        bus.req0_valid = 1'b0;
        check("full_rate", 128'(n_acc - base), 128'd100);
        tick(LATENCY + 12);
        check("full_drained", 128'(exp_q.size()), 128'h0);

        // Reset mid-flight
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            rand_data();
            bus.req0_valid = 1'b1;
            tick(1);
        end
        bus.req0_valid = 1'b0;
        tick(5);
        apply_reset();
        hi = 0;
        for (int i = 0; i < 2 * LATENCY; i++) begin
            tick(1);
            if (bus.res_valid) hi++;
        end
        check("mid_quiet", 128'(hi), 128'h0);
        check("mid_credits", 128'(dut.credits_q), 128'(FIFO_DEPTH));
        rand_data();
        bus.req1_valid = 1'b1;
        tick(1);
        bus.req1_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < LATENCY + 6 && seen == 0; i++) begin
            tick(1);
            if (bus.res_valid) seen = 1;
        end
        check("mid_new_block", 128'(seen), 128'h1);
        tick(4);

        // Random stall
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            rand_data();
            bus.req0_valid = 1'($urandom_range(1));
            bus.req1_valid = 1'($urandom_range(1));
            bus.res_ready  = 1'($urandom_range(1));
            tick(1);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.res_ready  = 1'b1;
        tick(LATENCY + FIFO_DEPTH + 20);
        check("rand_drained", 128'(exp_q.size()), 128'h0);
        check("rand_idle", 128'(bus.res_valid), 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
